// File: rtl/txt2data_hex_if.sv
// Text memory read port between txt2data_hex (master) and the 7-bit text RAM (slave).
interface txt2data_hex_if;
  logic [6:0] rd_addr;
  logic       rd_en;
  logic [6:0] rd_txt_dt;

  modport master (output rd_addr, output rd_en, input rd_txt_dt);
  modport slave  (input rd_addr, input rd_en, output rd_txt_dt);
endinterface

// File: rtl/txt2data_hex.sv
// Reads NCHAR ASCII hex characters from text memory and packs them into DATA_OUT.
// Optional macro HEX_LOWER_EN: also accept 'a'-'f' as valid hex digits.
module txt2data_hex #(
  parameter int NCHAR     = 44,
  parameter int DW        = 240,
  parameter int BASE_ADDR = 1,
  parameter int RD_LAT    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  txt2data_hex_if.master     mem,
  output logic [DW-1:0]      data_out_o,
  output logic               done_o,
  output logic               busy_o,
  output logic               err_o,
  output logic [6:0]         err_idx_o
);

  localparam int SW = 4 * NCHAR;

  // state   | meaning
  // IDLE    | waiting for a START rising edge
  // ISSUE   | one read per cycle, NCHAR reads
  // DRAIN   | waiting for the last character to return
  // DONE_S  | DONE pulse, DATA_OUT already updated
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        start_hist_q;
  logic              start_edge;
  logic [6:0]        cnt_q, cnt_d;
  logic [RD_LAT-1:0] vld_q;
  logic [6:0]        idx_q [RD_LAT];
  logic [SW-1:0]     shadow_q, shadow_d;
  logic [DW-1:0]     data_q;
  logic              err_q, err_d;
  logic [6:0]        err_idx_q, err_idx_d;
  logic              ret_vld;
  logic [6:0]        ret_idx;
  logic              ret_bad;
  logic [3:0]        ret_nib;

  // Returns {invalid, nibble}; invalid characters decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] c);
    if (c >= 7'h30 && c <= 7'h39) return {1'b0, c[3:0]};
    if (c >= 7'h41 && c <= 7'h46) return {1'b0, c[3:0] + 4'd9};
`ifdef HEX_LOWER_EN
    if (c >= 7'h61 && c <= 7'h66) return {1'b0, c[3:0] + 4'd9};
`endif
    return 5'h10;
  endfunction

  assign start_edge        = start_hist_q[0] & ~start_hist_q[1];
  assign ret_vld           = vld_q[RD_LAT-1];
  assign ret_idx           = idx_q[RD_LAT-1];
  assign {ret_bad, ret_nib} = decode(mem.rd_txt_dt);

  assign mem.rd_en   = (state_q == S_ISSUE);
  assign mem.rd_addr = (state_q == S_ISSUE) ? 7'(BASE_ADDR) + cnt_q : 7'd0;

  assign data_out_o = data_q;
  assign done_o     = (state_q == S_DONE);
  assign busy_o     = (state_q != S_IDLE);
  assign err_o      = err_q;
  assign err_idx_o  = err_idx_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;

    // Flipping the index LSB places the even character in the high nibble of each byte.
    if (ret_vld) begin
      shadow_d[{ret_idx ^ 7'd1, 2'b00} +: 4] = ret_nib;
      if (ret_bad && !err_q) begin
        err_d     = 1'b1;
        err_idx_d = ret_idx;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d   = S_ISSUE;
          cnt_d     = 7'd0;
          shadow_d  = '0;
          err_d     = 1'b0;
          err_idx_d = 7'd0;
        end
      end
      S_ISSUE: begin
        if (cnt_q != 7'(NCHAR)) cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'(NCHAR - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (ret_vld && ret_idx == 7'(NCHAR - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      start_hist_q <= 2'b00;
      cnt_q        <= 7'd0;
      vld_q        <= '0;
      for (int j = 0; j < RD_LAT; j++) idx_q[j] <= 7'd0;
      shadow_q     <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      err_idx_q    <= 7'd0;
    end else begin
      start_hist_q <= {start_hist_q[0], start_i};
      if (clr_i) begin
        // Abort drops any pending edge and discards in-flight returns.
        state_q   <= S_IDLE;
        cnt_q     <= 7'd0;
        vld_q     <= '0;
        shadow_q  <= '0;
        data_q    <= '0;
        err_q     <= 1'b0;
        err_idx_q <= 7'd0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        shadow_q  <= shadow_d;
        err_q     <= err_d;
        err_idx_q <= err_idx_d;
        vld_q[0]  <= (state_q == S_ISSUE);
        idx_q[0]  <= cnt_q;
        for (int j = 1; j < RD_LAT; j++) begin
          vld_q[j] <= vld_q[j-1];
          idx_q[j] <= idx_q[j-1];
        end
        if (state_q == S_DRAIN && state_d == S_DONE) data_q <= DW'(shadow_d);
      end
    end
  end

endmodule

// File: tb/tb_txt2data_hex.sv
// Directed bench for txt2data_hex with a queue scoreboard; two instances (RD_LAT 1 and 3).
module tb_txt2data_hex;
  localparam int NCHAR = 44;
  localparam int DW    = 240;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic [6:0]    idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, clr1, start3, clr3;
  logic [DW-1:0] d1, d3;
  logic done1, busy1, err1, done3, busy3, err3;
  logic [6:0] eidx1, eidx3;

  txt2data_hex_if m1 ();
  txt2data_hex_if m3 ();

  txt2data_hex #(.NCHAR(NCHAR), .DW(DW), .BASE_ADDR(1), .RD_LAT(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .clr_i(clr1), .mem(m1),
    .data_out_o(d1), .done_o(done1), .busy_o(busy1), .err_o(err1), .err_idx_o(eidx1));

  txt2data_hex #(.NCHAR(NCHAR), .DW(DW), .BASE_ADDR(1), .RD_LAT(3)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3), .clr_i(clr3), .mem(m3),
    .data_out_o(d3), .done_o(done3), .busy_o(busy3), .err_o(err3), .err_idx_o(eidx3));

  // Text memory; idle cycles return 'Z' so mis-tagged returns show up as errors.
  logic [6:0] text [128];
  logic [6:0] p1;
  logic [6:0] p3 [3];
  always @(posedge clk) p1 <= m1.rd_en ? text[m1.rd_addr] : 7'h5A;
  always @(posedge clk) begin
    p3[0] <= m3.rd_en ? text[m3.rd_addr] : 7'h5A;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m1.rd_txt_dt = p1;
  assign m3.rd_txt_dt = p3[2];

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  int done_k1, ndone1, done_k3, ndone3;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    logic [6:0] c;
    logic [3:0] nib;
    logic bad;
    int pos;
    e = '0;
    for (int k = 0; k < NCHAR; k++) begin
      c = text[1 + k];
      bad = 1'b0;
      if (c inside {[7'h30:7'h39]}) nib = 4'(c - 7'h30);
      else if (c inside {[7'h41:7'h46]}) nib = 4'(c - 7'h37);
`ifdef HEX_LOWER_EN
      else if (c inside {[7'h61:7'h66]}) nib = 4'(c - 7'h57);
`endif
      else begin
        nib = 4'd0;
        bad = 1'b1;
      end
      pos = (k % 2 == 0) ? 8 * (k / 2) + 4 : 8 * (k / 2);
      e.data[pos +: 4] = nib;
      if (bad && !e.err) begin
        e.err = 1'b1;
        e.idx = 7'(k);
      end
    end
    return e;
  endfunction

  task automatic fill_zero();
    for (int i = 0; i < 128; i++) text[i] = 7'h5A;
    for (int i = 1; i <= NCHAR; i++) text[i] = 7'h30;
  endtask

  // Scoreboard: every DONE pops one expected result.
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) chk("unexpected_done1", 256'(done1), 256'(1'b0));
      else begin
        e1 = q1.pop_front();
        chk("sb_data1", 256'(d1), 256'(e1.data));
        chk("sb_err1", 256'(err1), 256'(e1.err));
        chk("sb_err_idx1", 256'(eidx1), 256'(e1.idx));
      end
    end
    if (!rst && done3) begin
      if (q3.size() == 0) chk("unexpected_done3", 256'(done3), 256'(1'b0));
      else begin
        e3 = q3.pop_front();
        chk("sb_data3", 256'(d3), 256'(e3.data));
        chk("sb_err3", 256'(err3), 256'(e3.err));
        chk("sb_err_idx3", 256'(eidx3), 256'(e3.idx));
      end
    end
  end

  // k counts negedges after START goes high; first edge is sampled in cycle 1.
  task automatic run(input bit go3, input int ncyc, input int drop_k, input int rise_k,
                     input int clr_k, input int rst_k, input bit chk_rd, input bit hold,
                     input logic [DW-1:0] held);
    bit en_exp;
    start1 = 1'b0;
    start3 = 1'b0;
    repeat (2) @(negedge clk);
    start1 = 1'b1;
    if (go3) start3 = 1'b1;
    done_k1 = -1; ndone1 = 0; done_k3 = -1; ndone3 = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (done1) begin ndone1++; if (done_k1 < 0) done_k1 = k; end
      if (done3) begin ndone3++; if (done_k3 < 0) done_k3 = k; end
      if (chk_rd) begin
        en_exp = (k >= 2 && k <= NCHAR + 1);
        chk("rd_en1", 256'(m1.rd_en), 256'(en_exp));
        if (en_exp) chk("rd_addr1", 256'(m1.rd_addr), 256'(k - 1));
        chk("busy1", 256'(busy1), 256'(k >= 2 && k <= NCHAR + 3));
      end
      if (hold && k == 20) chk("data_hold1", 256'(d1), 256'(held));
      if (k == drop_k) start1 = 1'b0;
      if (k == rise_k) start1 = 1'b1;
      clr1 = (k == clr_k);
      rst  = (k == rst_k);
    end
    start1 = 1'b0; start3 = 1'b0; clr1 = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done1) ndone1++;
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; clr1 = 1'b0; clr3 = 1'b0;
    fill_zero();
    repeat (3) @(negedge clk);
    chk("rst_data1", 256'(d1), 256'(0));
    chk("rst_done1", 256'(done1), 256'(0));
    chk("rst_busy1", 256'(busy1), 256'(0));
    chk("rst_err1", 256'(err1), 256'(0));
    chk("rst_err_idx1", 256'(eidx1), 256'(0));
    chk("rst_rd_en1", 256'(m1.rd_en), 256'(0));
    chk("rst_rd_addr1", 256'(m1.rd_addr), 256'(0));
    chk("rst_busy3", 256'(busy3), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic read on both latencies
    fill_zero();
    text[1] = 7'h31; text[2] = 7'h32; text[3] = 7'h41; text[4] = 7'h42;
    q1.push_back(model());
    q3.push_back(model());
    run(1'b1, 60, 0, 0, 0, 0, 1'b1, 1'b0, '0);
    chk("done_lat1", 256'(done_k1), 256'(47));
    chk("ndone1", 256'(ndone1), 256'(1));
    chk("done_lat3", 256'(done_k3), 256'(49));
    chk("ndone3", 256'(ndone3), 256'(1));
    chk("data1_ab12", 256'(d1), 256'(16'hAB12));
    chk("data3_ab12", 256'(d3), 256'(16'hAB12));
    chk("err1_clean", 256'(err1), 256'(0));

    // Reset mid-transaction, then a fresh transaction
    q1.push_back(model());
    run(1'b0, 31, 5, 0, 0, 30, 1'b0, 1'b0, '0);
    q1.delete();
    chk("rstmid_data1", 256'(d1), 256'(0));
    chk("rstmid_busy1", 256'(busy1), 256'(0));
    chk("rstmid_rd_en1", 256'(m1.rd_en), 256'(0));
    chk("rstmid_done1", 256'(done1), 256'(0));
    q1.push_back(model());
    run(1'b0, 60, 5, 0, 0, 0, 1'b1, 1'b0, '0);
    chk("rerun_lat1", 256'(done_k1), 256'(47));
    chk("rerun_data1", 256'(d1), 256'(16'hAB12));

    // Second START edge during a transaction is ignored
    q1.push_back(model());
    run(1'b0, 120, 5, 9, 0, 0, 1'b1, 1'b1, DW'(16'hAB12));
    chk("overlap_ndone1", 256'(ndone1), 256'(1));
    chk("overlap_lat1", 256'(done_k1), 256'(47));

    // CLR at cycle 20
    q1.push_back(model());
    run(1'b0, 21, 5, 0, 20, 0, 1'b0, 1'b0, '0);
    q1.delete();
    chk("clr_busy1", 256'(busy1), 256'(0));
    chk("clr_data1", 256'(d1), 256'(0));
    chk("clr_err1", 256'(err1), 256'(0));
    idle(60);
    chk("clr_ndone1", 256'(ndone1), 256'(0));

    // CLR together with the START edge
    run(1'b0, 12, 0, 0, 1, 0, 1'b0, 1'b0, '0);
    chk("clrstart_busy1", 256'(busy1), 256'(0));
    chk("clrstart_rd_en1", 256'(m1.rd_en), 256'(0));
    chk("clrstart_ndone1", 256'(ndone1), 256'(0));

    // Non-hex characters
    fill_zero();
    text[7] = 7'h47; text[9] = 7'h20;
    q1.push_back(model());
    run(1'b0, 60, 5, 0, 0, 0, 1'b1, 1'b0, '0);
    chk("bad_ndone1", 256'(ndone1), 256'(1));
    chk("bad_err1", 256'(err1), 256'(1));
    chk("bad_err_idx1", 256'(eidx1), 256'(6));
    chk("bad_data1", 256'(d1), 256'(0));

    // Lowercase characters
    fill_zero();
    text[1] = 7'h66; text[2] = 7'h65;
    q1.push_back(model());
    run(1'b0, 60, 5, 0, 0, 0, 1'b1, 1'b0, '0);
    chk("lower_ndone1", 256'(ndone1), 256'(1));
`ifdef HEX_LOWER_EN
    chk("lower_data1", 256'(d1), 256'(8'hFE));
    chk("lower_err1", 256'(err1), 256'(0));
`else
    chk("lower_data1", 256'(d1), 256'(0));
    chk("lower_err1", 256'(err1), 256'(1));
    chk("lower_err_idx1", 256'(eidx1), 256'(0));
`endif

    idle(5);
    chk("sb_drained1", 256'(q1.size()), 256'(0));
    chk("sb_drained3", 256'(q3.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
